pipeline_mem_stage: RTL and testbench
=====================================

PIPELINE_MEM_STAGE -- requirements
Module: pipeline_mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, is the maximum number of WAIT cycles without dmem_ack before an access is aborted (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid_EX  input  1  EX/MEM register holds a live instruction.
REQ-005 alu_result_EX  input  64  effective address, or the ALU result for non-memory operations.
REQ-006 reg_data2_MEM  input  64  store data.
REQ-007 rd_MEM  input  5  destination register.
REQ-008 pc_out  input  64  PC of the instruction in MEM.
REQ-009 dm_rd_ctrl_EX  input  3  load type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD.
REQ-010 dm_wr_ctrl_EX  input  2  store type: 0 none, 1 SB, 2 SH, 3 SW.
REQ-011 dmem_req, dmem_we  output  1 each  data-memory request strobe and write enable.
REQ-012 dmem_addr  output  64  doubleword-aligned address.
REQ-013 dmem_wdata  output  64  write data; dmem_be  output  8  byte enables.
REQ-014 dmem_rdata  input  64  read data; dmem_ack  input  1  single-cycle completion pulse.
REQ-015 stall_MEM  output  1  freezes the EX/MEM register and all upstream stages.
REQ-016 valid_WB, mem_err_WB  output  1 each  write-back valid and access-error flag.
REQ-017 rd_WB  output  5; wb_data_WB  output  64; pc_WB  output  64  registered write-back payload.

Function
REQ-018 The block SHALL implement a two-state FSM: IDLE and WAIT.
REQ-019 A memory op is valid_EX with dm_rd_ctrl_EX!=0 or dm_wr_ctrl_EX!=0.
REQ-020 A valid non-memory op in IDLE SHALL produce, at the next edge: valid_WB=1, wb_data_WB=alu_result_EX, rd_WB=rd_MEM, pc_WB=pc_out, mem_err_WB=0. This is 1-cycle latency with no stall.
REQ-021 Alignment: an access is misaligned when halfword addr[0]!=0, word addr[1:0]!=0, or LD addr[2:0]!=0.
REQ-022 A memory op in IDLE with both ctrl fields nonzero, or with a misaligned address, SHALL issue no dmem_req. It SHALL produce a one-cycle result with valid_WB=1, mem_err_WB=1 and wb_data_WB=0, and SHALL stay in IDLE.
REQ-023 A legal memory op in IDLE SHALL transition to WAIT at the next edge.
REQ-024 On that transition the block SHALL register dmem_req=1, dmem_we=(store), dmem_addr={addr[63:3],3'b000}, dmem_wdata and dmem_be.
REQ-025 Store lanes: dmem_wdata SHALL be the store data replicated across lanes.
REQ-026 Store byte enables: dmem_be SHALL be 8'h01 for SB, 8'h03 for SH and 8'h0F for SW, each shifted left by addr[2:0].
REQ-027 In WAIT, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be SHALL remain stable until dmem_ack or timeout.
REQ-028 stall_MEM SHALL be combinational: stall_MEM = (IDLE and legal memory op) or (WAIT and not dmem_ack).
REQ-029 On dmem_ack in WAIT, at the next edge the block SHALL deassert dmem_req, return to IDLE and pulse valid_WB for one cycle.
REQ-030 Load formatting: for loads, wb_data_WB SHALL be the lane selected by addr[2:0] from dmem_rdata, sign- or zero-extended per dm_rd_ctrl to 64 bits.
REQ-031 Store completion: for stores, wb_data_WB SHALL be 0 and rd_WB SHALL be 0.
REQ-032 A WAIT-cycle counter SHALL clear on entry to WAIT. If it reaches ACK_TIMEOUT without dmem_ack, the block SHALL drop dmem_req, pulse valid_WB=1 with mem_err_WB=1, and return to IDLE.
REQ-033 If dmem_ack arrives in the same cycle the counter reaches ACK_TIMEOUT, the ack SHALL win and mem_err_WB SHALL be 0.
REQ-034 dmem_ack received in IDLE SHALL be ignored.
REQ-035 In all other cycles valid_WB and mem_err_WB SHALL be 0. rd_WB, wb_data_WB and pc_WB SHALL hold their previous values.
REQ-036 valid_EX=0 in IDLE SHALL produce valid_WB=0 and no request.

Reset
REQ-037 While reset is high: state=IDLE, counter=0, and all outputs 0, including stall_MEM (dmem_be=8'h00).
REQ-038 Reset asserted mid-WAIT SHALL drop dmem_req immediately, with no valid_WB pulse. A dmem_ack arriving after reset release SHALL be ignored.

Verification
REQ-039 ALU pass-through: valid_EX=1, ctrl=0, alu_result_EX=64'h1234, rd_MEM=5 -> next cycle valid_WB=1, wb_data_WB=64'h1234, rd_WB=5, stall_MEM never high.
REQ-040 LB with sign extension: addr=64'h1003, rd_ctrl=1, dmem_rdata=64'h00000000_80000000 with ack after 3 cycles -> dmem_addr=64'h1000; stall_MEM high 4 cycles; wb_data_WB=64'hFFFF_FFFF_FFFF_FF80.
REQ-041 SH at addr 64'h2006, data 64'hABCD -> dmem_we=1, dmem_be=8'hC0, dmem_wdata=64'hABCD_ABCD_ABCD_ABCD; valid_WB=1 after ack with rd_WB=0.
REQ-042 Misaligned LW at addr 64'h2002 -> no dmem_req; next cycle valid_WB=1 and mem_err_WB=1.
REQ-043 Timeout: legal LD with dmem_ack never asserted -> dmem_req drops after exactly 15 WAIT cycles, mem_err_WB=1, FSM back in IDLE.
REQ-044 Reset during WAIT -> dmem_req=0 and stall_MEM=0 immediately; a later ack produces no valid_WB.

Source files
------------

// File: rtl/pipeline_mem_stage.sv
// Memory stage of the integer pipeline. Non-memory instructions pass their
// ALU result through in one cycle. Loads and stores issue one registered
// request to the data memory and wait for a single-cycle ack, or give up
// after ACK_TIMEOUT wait cycles and retire the instruction with an error.
// Illegal accesses (misaligned, or both load and store set) retire at once
// with an error and never reach the memory.
//
// Handshake: dmem_req is a level that stays high, with addr/we/wdata/be held
// stable, from the cycle after issue until the cycle after dmem_ack is seen
// (or the timeout fires); dmem_ack is a one-cycle pulse and is only honoured
// while a request is outstanding. stall_MEM is high while the instruction in
// EX/MEM cannot yet retire, which holds the request inputs stable upstream.
module pipeline_mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_EX,
  input  logic [63:0] alu_result_EX,
  input  logic [63:0] reg_data2_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic [63:0] pc_out,
  input  logic [2:0]  dm_rd_ctrl_EX,
  input  logic [1:0]  dm_wr_ctrl_EX,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_MEM,
  output logic        valid_WB,
  output logic        mem_err_WB,
  output logic [4:0]  rd_WB,
  output logic [63:0] wb_data_WB,
  output logic [63:0] pc_WB,
  output logic        dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // Counter value in the last permitted wait cycle.
  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [2:0]  ld_ctrl_q;
  logic [2:0]  lane_q;
  logic        store_q;
  logic [4:0]  rd_q;
  logic [63:0] pc_q;

  logic        is_load, is_store, mem_op, misaligned, bad_op, legal_op;
  logic        timeout;
  logic [2:0]  a_lo;

  assign a_lo      = alu_result_EX[2:0];
  assign dbg_state = state_q;
  assign timeout   = (state_q == S_WAIT) && !dmem_ack && (cnt_q == CNT_LAST);

  // Lane select plus sign/zero extension of returned load data.
  function automatic logic [63:0] format_load(input logic [63:0] rdata,
                                              input logic [2:0]  lane,
                                              input logic [2:0]  ctrl);
    logic [63:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (ctrl)
      3'd1:    format_load = {{56{sh[7]}},  sh[7:0]};
      3'd2:    format_load = {56'd0,        sh[7:0]};
      3'd3:    format_load = {{48{sh[15]}}, sh[15:0]};
      3'd4:    format_load = {48'd0,        sh[15:0]};
      3'd5:    format_load = {{32{sh[31]}}, sh[31:0]};
      3'd6:    format_load = {32'd0,        sh[31:0]};
      3'd7:    format_load = sh;
      default: format_load = 64'd0;
    endcase
  endfunction

  // Classify the instruction sitting in EX/MEM.
  always_comb begin
    is_load    = (dm_rd_ctrl_EX != 3'd0);
    is_store   = (dm_wr_ctrl_EX != 2'd0);
    mem_op     = valid_EX && (is_load || is_store);
    misaligned = 1'b0;
    if (is_load) begin
      case (dm_rd_ctrl_EX)
        3'd3, 3'd4: misaligned = a_lo[0];
        3'd5, 3'd6: misaligned = (a_lo[1:0] != 2'b00);
        3'd7:       misaligned = (a_lo != 3'b000);
        default:    misaligned = 1'b0;
      endcase
    end else if (is_store) begin
      case (dm_wr_ctrl_EX)
        2'd2:    misaligned = a_lo[0];
        2'd3:    misaligned = (a_lo[1:0] != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
    bad_op   = (is_load && is_store) || misaligned;
    legal_op = mem_op && !bad_op;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: enter WAIT on a legal access, leave on ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (legal_op) state_d = S_WAIT;
      S_WAIT:  if (dmem_ack || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stall output: hold upstream while an access is being issued or pending.
  always_comb begin
    stall_MEM = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE:  stall_MEM = legal_op;
        S_WAIT:  stall_MEM = !dmem_ack;
        default: stall_MEM = 1'b0;
      endcase
    end
  end

  // Request registers, wait counter and write-back payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 64'd0;
      dmem_wdata <= 64'd0;
      dmem_be    <= 8'h00;
      valid_WB   <= 1'b0;
      mem_err_WB <= 1'b0;
      rd_WB      <= 5'd0;
      wb_data_WB <= 64'd0;
      pc_WB      <= 64'd0;
      ld_ctrl_q  <= 3'd0;
      lane_q     <= 3'd0;
      store_q    <= 1'b0;
      rd_q       <= 5'd0;
      pc_q       <= 64'd0;
    end else begin
      valid_WB   <= 1'b0;
      mem_err_WB <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_EX && !mem_op) begin
            valid_WB   <= 1'b1;
            wb_data_WB <= alu_result_EX;
            rd_WB      <= rd_MEM;
            pc_WB      <= pc_out;
          end else if (mem_op && bad_op) begin
            valid_WB   <= 1'b1;
            mem_err_WB <= 1'b1;
            wb_data_WB <= 64'd0;
            rd_WB      <= rd_MEM;
            pc_WB      <= pc_out;
          end else if (legal_op) begin
            cnt_q     <= 8'd0;
            dmem_req  <= 1'b1;
            dmem_we   <= is_store;
            dmem_addr <= {alu_result_EX[63:3], 3'b000};
            ld_ctrl_q <= dm_rd_ctrl_EX;
            lane_q    <= a_lo;
            store_q   <= is_store;
            rd_q      <= rd_MEM;
            pc_q      <= pc_out;
            case (dm_wr_ctrl_EX)
              2'd1: begin
                dmem_wdata <= {8{reg_data2_MEM[7:0]}};
                dmem_be    <= 8'h01 << a_lo;
              end
              2'd2: begin
                dmem_wdata <= {4{reg_data2_MEM[15:0]}};
                dmem_be    <= 8'h03 << a_lo;
              end
              2'd3: begin
                dmem_wdata <= {2{reg_data2_MEM[31:0]}};
                dmem_be    <= 8'h0F << a_lo;
              end
              default: begin
                dmem_wdata <= 64'd0;
                dmem_be    <= 8'h00;
              end
            endcase
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            valid_WB   <= 1'b1;
            pc_WB      <= pc_q;
            rd_WB      <= store_q ? 5'd0 : rd_q;
            wb_data_WB <= store_q ? 64'd0 : format_load(dmem_rdata, lane_q, ld_ctrl_q);
          end else if (timeout) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            valid_WB   <= 1'b1;
            mem_err_WB <= 1'b1;
            pc_WB      <= pc_q;
            rd_WB      <= store_q ? 5'd0 : rd_q;
            wb_data_WB <= 64'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed bench for pipeline_mem_stage: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_pipeline_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_EX;
  logic [63:0] alu_result_EX, reg_data2_MEM, pc_out;
  logic [4:0]  rd_MEM;
  logic [2:0]  dm_rd_ctrl_EX;
  logic [1:0]  dm_wr_ctrl_EX;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_be;
  logic        dmem_ack;
  logic        stall_MEM, valid_WB, mem_err_WB;
  logic [4:0]  rd_WB;
  logic [63:0] wb_data_WB, pc_WB;
  logic        dbg_state;

  int checks   = 0;
  int failures = 0;

  pipeline_mem_stage #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .valid_EX(valid_EX), .alu_result_EX(alu_result_EX),
    .reg_data2_MEM(reg_data2_MEM), .rd_MEM(rd_MEM), .pc_out(pc_out),
    .dm_rd_ctrl_EX(dm_rd_ctrl_EX), .dm_wr_ctrl_EX(dm_wr_ctrl_EX),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall_MEM(stall_MEM), .valid_WB(valid_WB),
    .mem_err_WB(mem_err_WB), .rd_WB(rd_WB), .wb_data_WB(wb_data_WB),
    .pc_WB(pc_WB), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Advance one edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_EX      = 1'b0;
    alu_result_EX = 64'd0;
    reg_data2_MEM = 64'd0;
    rd_MEM        = 5'd0;
    pc_out        = 64'd0;
    dm_rd_ctrl_EX = 3'd0;
    dm_wr_ctrl_EX = 2'd0;
    dmem_ack      = 1'b0;
    dmem_rdata    = 64'd0;
  endtask

  task automatic drive_op(input logic [63:0] addr, input logic [2:0] rc,
                          input logic [1:0] wc, input logic [4:0] rd,
                          input logic [63:0] pc, input logic [63:0] data);
    valid_EX = 1'b1; alu_result_EX = addr; dm_rd_ctrl_EX = rc;
    dm_wr_ctrl_EX = wc; rd_MEM = rd; pc_out = pc; reg_data2_MEM = data;
  endtask

  task automatic test_reset();
    idle_inputs();
    drive_op(64'h1000, 3'd7, 2'd0, 5'd3, 64'h40, 64'd0);
    reset = 1'b1;
    #1;
    checks++; if (stall_MEM !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_MEM); end
    tick();
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
    checks++; if (dmem_be !== 8'h00) begin failures++; $display("FAIL reset_be got=%h exp=00", dmem_be); end
    checks++; if (dmem_addr !== 64'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", dmem_addr); end
    checks++; if (valid_WB !== 1'b0 || mem_err_WB !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b%b exp=00", valid_WB, mem_err_WB); end
    checks++; if (wb_data_WB !== 64'd0 || rd_WB !== 5'd0 || pc_WB !== 64'd0) begin failures++; $display("FAIL reset_wb got=%h/%0d/%h exp=0", wb_data_WB, rd_WB, pc_WB); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu_pass();
    drive_op(64'h1234, 3'd0, 2'd0, 5'd5, 64'h100, 64'hDEAD);
    #1;
    checks++; if (stall_MEM !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall_MEM); end
    tick();
    checks++; if (valid_WB !== 1'b1 || mem_err_WB !== 1'b0) begin failures++; $display("FAIL alu_valid got=%b%b exp=10", valid_WB, mem_err_WB); end
    checks++; if (wb_data_WB !== 64'h1234) begin failures++; $display("FAIL alu_data got=%h exp=1234", wb_data_WB); end
    checks++; if (rd_WB !== 5'd5 || pc_WB !== 64'h100) begin failures++; $display("FAIL alu_rd_pc got=%0d/%h exp=5/100", rd_WB, pc_WB); end
    checks++; if (stall_MEM !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL alu_noreq got=%b%b exp=00", stall_MEM, dmem_req); end
    idle_inputs();
    tick();
    checks++; if (valid_WB !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", valid_WB); end
    checks++; if (wb_data_WB !== 64'h1234 || rd_WB !== 5'd5) begin failures++; $display("FAIL idle_hold got=%h/%0d exp=1234/5", wb_data_WB, rd_WB); end
  endtask

  task automatic test_lb_sign();
    int stall_cycles;
    stall_cycles = 0;
    drive_op(64'h1003, 3'd1, 2'd0, 5'd7, 64'h200, 64'd0);
    #1;
    if (stall_MEM === 1'b1) stall_cycles++;
    tick();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin failures++; $display("FAIL lb_req got=%b%b exp=10", dmem_req, dmem_we); end
    checks++; if (dmem_addr !== 64'h1000) begin failures++; $display("FAIL lb_addr got=%h exp=1000", dmem_addr); end
    checks++; if (dbg_state !== 1'b1) begin failures++; $display("FAIL lb_state got=%b exp=1", dbg_state); end
    for (int i = 0; i < 3; i++) begin
      if (stall_MEM === 1'b1) stall_cycles++;
      tick();
    end
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h1000) begin failures++; $display("FAIL lb_stable got=%b/%h exp=1/1000", dmem_req, dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 64'h00000000_80000000;
    #1;
    if (stall_MEM === 1'b1) stall_cycles++;
    checks++; if (stall_cycles !== 4) begin failures++; $display("FAIL lb_stall_cycles got=%0d exp=4", stall_cycles); end
    tick();
    idle_inputs();
    checks++; if (valid_WB !== 1'b1 || mem_err_WB !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL lb_done got=%b%b%b exp=100", valid_WB, mem_err_WB, dmem_req); end
    checks++; if (wb_data_WB !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffffffffffff80", wb_data_WB); end
    checks++; if (rd_WB !== 5'd7 || pc_WB !== 64'h200) begin failures++; $display("FAIL lb_rd_pc got=%0d/%h exp=7/200", rd_WB, pc_WB); end
    tick();
    checks++; if (valid_WB !== 1'b0 || dbg_state !== 1'b0) begin failures++; $display("FAIL lb_pulse got=%b/%b exp=0/0", valid_WB, dbg_state); end
  endtask

  task automatic test_sh_store();
    drive_op(64'h2006, 3'd0, 2'd2, 5'd9, 64'h300, 64'hABCD);
    tick();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin failures++; $display("FAIL sh_req got=%b%b exp=11", dmem_req, dmem_we); end
    checks++; if (dmem_be !== 8'hC0) begin failures++; $display("FAIL sh_be got=%h exp=c0", dmem_be); end
    checks++; if (dmem_wdata !== 64'hABCD_ABCD_ABCD_ABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcdabcdabcd", dmem_wdata); end
    checks++; if (dmem_addr !== 64'h2000) begin failures++; $display("FAIL sh_addr got=%h exp=2000", dmem_addr); end
    tick();
    dmem_ack = 1'b1;
    tick();
    idle_inputs();
    checks++; if (valid_WB !== 1'b1 || mem_err_WB !== 1'b0) begin failures++; $display("FAIL sh_done got=%b%b exp=10", valid_WB, mem_err_WB); end
    checks++; if (rd_WB !== 5'd0 || wb_data_WB !== 64'd0) begin failures++; $display("FAIL sh_rd_data got=%0d/%h exp=0/0", rd_WB, wb_data_WB); end
    // SW at lane 4 and SB at lane 5: lane replication and byte-enable shift.
    drive_op(64'h2004, 3'd0, 2'd3, 5'd1, 64'h304, 64'h1122_3344_5566_7788);
    tick();
    checks++; if (dmem_be !== 8'hF0 || dmem_wdata !== 64'h5566_7788_5566_7788) begin failures++; $display("FAIL sw_lane got=%h/%h exp=f0/5566778855667788", dmem_be, dmem_wdata); end
    dmem_ack = 1'b1;
    tick();
    idle_inputs();
    drive_op(64'h2005, 3'd0, 2'd1, 5'd1, 64'h308, 64'h00A5);
    tick();
    checks++; if (dmem_be !== 8'h20 || dmem_wdata !== 64'hA5A5_A5A5_A5A5_A5A5) begin failures++; $display("FAIL sb_lane got=%h/%h exp=20/a5a5a5a5a5a5a5a5", dmem_be, dmem_wdata); end
    dmem_ack = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_load_formats();
    logic [63:0] addrs [4];
    logic [2:0]  ctrls [4];
    logic [63:0] exps  [4];
    addrs = '{64'h4004, 64'h4004, 64'h4002, 64'h4008};
    ctrls = '{3'd5,     3'd6,     3'd4,     3'd7};
    exps  = '{64'hFFFF_FFFF_89AB_CDEF, 64'h0000_0000_89AB_CDEF,
              64'h0000_0000_0000_0123, 64'h89AB_CDEF_0123_4567};
    for (int i = 0; i < 4; i++) begin
      drive_op(addrs[i], ctrls[i], 2'd0, 5'd12, 64'h500, 64'd0);
      tick();
      dmem_ack = 1'b1; dmem_rdata = 64'h89AB_CDEF_0123_4567;
      tick();
      idle_inputs();
      checks++; if (valid_WB !== 1'b1 || wb_data_WB !== exps[i]) begin failures++; $display("FAIL load_fmt%0d got=%b/%h exp=1/%h", i, valid_WB, wb_data_WB, exps[i]); end
    end
    tick();
  endtask

  task automatic test_illegal();
    drive_op(64'h2002, 3'd5, 2'd0, 5'd4, 64'h600, 64'd0);
    #1;
    checks++; if (stall_MEM !== 1'b0) begin failures++; $display("FAIL mis_stall got=%b exp=0", stall_MEM); end
    tick();
    checks++; if (dmem_req !== 1'b0 || dbg_state !== 1'b0) begin failures++; $display("FAIL mis_noreq got=%b/%b exp=0/0", dmem_req, dbg_state); end
    checks++; if (valid_WB !== 1'b1 || mem_err_WB !== 1'b1 || wb_data_WB !== 64'd0) begin failures++; $display("FAIL mis_err got=%b%b/%h exp=11/0", valid_WB, mem_err_WB, wb_data_WB); end
    // Aligned address but both load and store requested.
    drive_op(64'h2000, 3'd7, 2'd3, 5'd4, 64'h604, 64'd0);
    tick();
    checks++; if (dmem_req !== 1'b0 || valid_WB !== 1'b1 || mem_err_WB !== 1'b1) begin failures++; $display("FAIL both_err got=%b%b%b exp=011", dmem_req, valid_WB, mem_err_WB); end
    idle_inputs();
    tick();
    checks++; if (mem_err_WB !== 1'b0 || valid_WB !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b%b exp=00", valid_WB, mem_err_WB); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    drive_op(64'h3000, 3'd7, 2'd0, 5'd8, 64'h700, 64'd0);
    tick();
    while (dmem_req === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    idle_inputs();
    checks++; if (n !== 15) begin failures++; $display("FAIL timeout_cycles got=%0d exp=15", n); end
    checks++; if (valid_WB !== 1'b1 || mem_err_WB !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b%b exp=11", valid_WB, mem_err_WB); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL timeout_state got=%b exp=0", dbg_state); end
    tick();
  endtask

  task automatic test_ack_at_timeout();
    drive_op(64'h3008, 3'd7, 2'd0, 5'd10, 64'h800, 64'd0);
    tick();
    for (int i = 0; i < 14; i++) tick();
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL edge_req got=%b exp=1", dmem_req); end
    dmem_ack = 1'b1; dmem_rdata = 64'h0BAD_F00D_CAFE_0001;
    tick();
    idle_inputs();
    checks++; if (valid_WB !== 1'b1 || mem_err_WB !== 1'b0 || wb_data_WB !== 64'h0BAD_F00D_CAFE_0001) begin failures++; $display("FAIL edge_ack got=%b%b/%h exp=10/0badf00dcafe0001", valid_WB, mem_err_WB, wb_data_WB); end
    tick();
  endtask

  task automatic test_ack_in_idle();
    dmem_ack = 1'b1; dmem_rdata = 64'hFFFF;
    tick();
    dmem_ack = 1'b0;
    checks++; if (valid_WB !== 1'b0 || dmem_req !== 1'b0 || dbg_state !== 1'b0) begin failures++; $display("FAIL idle_ack got=%b%b%b exp=000", valid_WB, dmem_req, dbg_state); end
  endtask

  task automatic test_reset_mid_wait();
    drive_op(64'h5000, 3'd7, 2'd0, 5'd11, 64'h900, 64'd0);
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0 || stall_MEM !== 1'b0) begin failures++; $display("FAIL rstwait_drop got=%b%b exp=00", dmem_req, stall_MEM); end
    idle_inputs();
    tick();
    @(negedge clk);
    reset = 1'b0;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    checks++; if (valid_WB !== 1'b0 || dbg_state !== 1'b0) begin failures++; $display("FAIL rstwait_ack got=%b/%b exp=0/0", valid_WB, dbg_state); end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_alu_pass();
    test_lb_sign();
    test_sh_store();
    test_load_formats();
    test_illegal();
    test_timeout();
    test_ack_at_timeout();
    test_ack_in_idle();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
